// File: rtl/toggle_monitor_pkg.sv
// Shared types and widths for the toggle_monitor receive-side checker.
package toggle_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam int unsigned ERR_CNT_W    = 16;
  localparam int unsigned TOGGLE_CNT_W = 32;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/toggle_monitor_edge_sync_detect.sv
// Two-flop synchronizer for an asynchronous line plus a history flop;
// edge_o flags either polarity of change on the synchronized level.
module edge_sync_detect (
  input  logic clk_i,
  input  logic srst_i,
  input  logic sig_i,
  output logic edge_o,
  output logic level_o
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_i;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_o  = sync2 ^ prev;
  assign level_o = sync2;

endmodule

// File: rtl/toggle_monitor.sv
// Receive-side checker for the LED blinker: counts edges on an async line,
// measures edge spacing against 2**CNT_WIDTH +/- TOL and reports lock/error.
module toggle_monitor
  import toggle_monitor_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned PER_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    sig_i,
  output logic [TOGGLE_CNT_W-1:0] toggle_cnt_o,
  output logic [PER_WIDTH-1:0]    last_period_o,
  output logic                    period_vld_o,
  output logic                    locked_o,
  output logic                    err_o,
  output logic [ERR_CNT_W-1:0]    err_cnt_o
);

  localparam int unsigned EXP  = 1 << CNT_WIDTH;
  localparam int unsigned GR_W = $clog2(LOCK_COUNT + 1);
  localparam logic [PER_WIDTH-1:0] PER_HI  = PER_WIDTH'(EXP + TOL);
  localparam logic [PER_WIDTH-1:0] PER_LO  = PER_WIDTH'(EXP - TOL);
  localparam logic [GR_W-1:0]      GR_LOCK = GR_W'(LOCK_COUNT);

  state_t               state_q;
  logic [PER_WIDTH-1:0] per_cnt_q;
  logic [GR_W-1:0]      good_run_q;
  logic [GR_W-1:0]      gr_inc;
  logic                 edge_s, level_unused;
  logic                 running, check, in_tol, timeout, err_evt;

  edge_sync_detect u_sync (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .sig_i   (sig_i),
    .edge_o  (edge_s),
    .level_o (level_unused)
  );

  // per_cnt == 0 outside IDLE means a timeout discarded the reference edge,
  // so the next edge only re-arms the measurement.
  assign running = en_i && (state_q != IDLE);
  assign check   = running && edge_s && (per_cnt_q != '0);
  assign in_tol  = (per_cnt_q >= PER_LO) && (per_cnt_q <= PER_HI);
  assign timeout = running && !edge_s && (per_cnt_q == PER_HI);
  assign err_evt = (check && !in_tol) || timeout;
  assign gr_inc  = good_run_q + GR_W'(1);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q       <= IDLE;
      per_cnt_q     <= '0;
      good_run_q    <= '0;
      toggle_cnt_o  <= '0;
      last_period_o <= '0;
      period_vld_o  <= 1'b0;
      locked_o      <= 1'b0;
      err_o         <= 1'b0;
      err_cnt_o     <= '0;
    end else begin
      period_vld_o <= check;
      if (check) last_period_o <= per_cnt_q;

      if (clr_i)                toggle_cnt_o <= '0;
      else if (en_i && edge_s)  toggle_cnt_o <= toggle_cnt_o + 1'b1;

      if (err_evt) begin
        err_o     <= 1'b1;
        err_cnt_o <= clr_i ? ERR_CNT_W'(1) : sat_inc(err_cnt_o);
      end else if (clr_i) begin
        err_o     <= 1'b0;
        err_cnt_o <= '0;
      end

      // An edge landing on the timeout threshold is handled before the timeout.
      if (!en_i) begin
        state_q    <= IDLE;
        per_cnt_q  <= '0;
        good_run_q <= '0;
        locked_o   <= 1'b0;
      end else if (edge_s) begin
        per_cnt_q <= PER_WIDTH'(1);
        if (!check) begin
          state_q    <= FIRST;
          good_run_q <= '0;
          locked_o   <= 1'b0;
        end else if (!in_tol) begin
          state_q    <= TRACK;
          good_run_q <= '0;
          locked_o   <= 1'b0;
        end else if ((state_q == LOCK) || (gr_inc == GR_LOCK)) begin
          state_q    <= LOCK;
          good_run_q <= GR_LOCK;
          locked_o   <= 1'b1;
        end else begin
          state_q    <= TRACK;
          good_run_q <= gr_inc;
          locked_o   <= 1'b0;
        end
      end else if (timeout) begin
        state_q    <= FIRST;
        per_cnt_q  <= '0;
        good_run_q <= '0;
        locked_o   <= 1'b0;
      end else if (running && (per_cnt_q != '0)) begin
        per_cnt_q <= per_cnt_q + 1'b1;
      end
    end
  end

endmodule
